// File: rtl/convolution_2d_pkg.sv
// convolution_2d_pkg: shared FSM state encodings and default counter width for the convolution_2d go/done controller
package convolution_2d_pkg;
  localparam int DEF_CNT_WIDTH = 32;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/convolution_2d_go_done_if.sv
// convolution_2d_go_done_if: go/done bundle; master = controller (in: go_sync, core_ready, core_done; out: start, busy, done_out, timeout, proto_err, cycles), slave = its environment
interface convolution_2d_go_done_if import convolution_2d_pkg::*; #(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
  logic go_sync;
  logic core_ready;
  logic core_done;
  logic start;
  logic busy;
  logic done_out;
  logic timeout;
  logic proto_err;
  logic [CNT_WIDTH-1:0] cycles;
  modport master(
    input  go_sync, core_ready, core_done,
    output start, busy, done_out, timeout, proto_err, cycles
  );
  modport slave(
    output go_sync, core_ready, core_done,
    input  start, busy, done_out, timeout, proto_err, cycles
  );
endinterface

// File: rtl/convolution_2d_go_done.sv
// convolution_2d_go_done: four-phase go/done controller with run-cycle counter, watchdog and sticky protocol error; ports clk, reset_n (async, active-low), bus (master modport of convolution_2d_go_done_if)
module convolution_2d_go_done import convolution_2d_pkg::*; #(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int TIMEOUT   = 0
) (
  input logic clk,
  input logic reset_n,
  convolution_2d_go_done_if.master bus
);
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT);
  logic [1:0] st, nxt;
  logic wd, launch, bump;
  logic start_q, busy_q, done_q, to_q, pe_q;
  logic [CNT_WIDTH-1:0] cyc;
  always_comb begin
    wd = TIMEOUT != 0 && cyc >= LIMIT;
    nxt = st == ST_IDLE  ? (bus.go_sync && bus.core_ready ? ST_START : ST_IDLE) :
          st == ST_START ? (bus.core_done ? ST_DONE : ST_RUN) :
          st == ST_RUN   ? (bus.core_done || wd ? ST_DONE : ST_RUN) :
                           (bus.go_sync ? ST_DONE : ST_IDLE);
    launch = nxt == ST_START;
    // the counter freezes on a watchdog exit so it reports the limit it hit
    bump = st == ST_RUN && (bus.core_done || !wd);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st      <= ST_IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      pe_q    <= 1'b0;
      cyc     <= '0;
    end else begin
      st      <= nxt;
      start_q <= launch;
      busy_q  <= launch || nxt == ST_RUN;
      done_q  <= nxt == ST_DONE;
      cyc     <= launch ? CNT_WIDTH'(1) : bump ? (&cyc ? cyc : cyc + CNT_WIDTH'(1)) : cyc;
      to_q    <= launch ? 1'b0 : (st == ST_RUN && !bus.core_done && wd) ? 1'b1 : to_q;
      pe_q    <= launch ? 1'b0 : ((st == ST_START || st == ST_RUN) && !bus.go_sync) ? 1'b1 : pe_q;
    end
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.done_out  = done_q;
  assign bus.timeout   = to_q;
  assign bus.proto_err = pe_q;
  assign bus.cycles    = cyc;
endmodule

// File: doc/convolution_2d_go_done.md
# convolution_2d_go_done

Four-phase go/done handshake controller on the core-clock side of the convolution_2d block. It consumes the level `go` after the multi-flip-flop synchronizer and issues a single-cycle `start` to the convolution core. It waits for the core's `done` pulse, then returns a `done` level for the CSR domain, which re-synchronizes it. It also provides a run-cycle counter, an optional watchdog timeout and a sticky protocol-error flag.

## Interface
- `CNT_WIDTH`, 32: width of the run-cycle counter.
- `TIMEOUT`, 0: watchdog limit in run cycles; 0 disables the watchdog.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clk`  in  1  core clock.
- `go_sync`  in  1  synchronized go level from the CSR domain, active high.
- `core_ready`  in  1  core idle and able to accept `start`.
- `core_done`  in  1  single-cycle completion pulse from the core.
- `start`  out  1  single-cycle start pulse to the core.
- `busy`  out  1  high in START and RUN.
- `done_out`  out  1  done level to the CSR domain; crosses through a synchronizer.
- `timeout`  out  1  last run ended by the watchdog.
- `proto_err`  out  1  sticky; set when `go_sync` falls before `done_out` rises.
- `cycles`  out  CNT_WIDTH  run-cycle count of the current or last run.

## Operation
- All outputs are registered.
- Reset values: state IDLE, every output 0, `cycles` 0.
- **IDLE**
  - If `go_sync`=1 and `core_ready`=1, go to START.
  - If `go_sync`=1 and `core_ready`=0, wait in IDLE.
- **START** (exactly one cycle)
  - `start`=1 and `busy`=1.
  - `cycles` is set to 1; `timeout` and `proto_err` are cleared.
  - If `core_done`=1 in this cycle, go to DONE; otherwise go to RUN.
- **RUN**
  - `busy`=1.
  - `cycles` increments each cycle and saturates at all-ones.
  - `core_done`=1 → DONE.
  - Otherwise, if `TIMEOUT`≠0 and `cycles`≥`TIMEOUT` → DONE, with `timeout` set to 1.
  - `core_done` and timeout in the same cycle: `core_done` wins and `timeout` stays 0.
  - `go_sync` falling while in START or RUN sets `proto_err`=1. The run is not aborted and continues to DONE normally.
- **DONE**
  - `done_out`=1 and `busy`=0; `cycles` holds.
  - Exit to IDLE when `go_sync`=0 is sampled.
  - The minimum stay is one cycle, even if `go_sync` is already 0.
- **IDLE after a run**
  - `done_out`=0.
  - `cycles`, `timeout` and `proto_err` hold until the next START.
- New go: `go_sync` must be seen as 0 in IDLE or DONE before a new run can begin. A level still high from the previous run never re-triggers a run, because DONE exits only on `go_sync`=0.
- `core_done` outside START/RUN is ignored.
- Reset asserted mid-operation returns the block to IDLE with all outputs 0 immediately (asynchronous). No `start` is issued after reset until a new `go_sync` high is seen with `core_ready`=1.

## Timing
- `go_sync` sampled high at edge N (with `core_ready`=1) → `start`=1 from edge N+1 to edge N+2.
- `core_done` sampled high at edge M → `done_out`=1 from edge M+1; `busy`=0 from edge M+1.
- `go_sync` sampled low at edge K in DONE → `done_out`=0 from edge K+1.
- `cycles` equals the number of clock cycles in START plus RUN.
- Watchdog: with `TIMEOUT`=T and no `core_done`, `done_out` rises T+1 cycles after `start` rises.
- Round-trip latency seen from the CSR domain also includes the two synchronizer stages in each direction.

## Structure
- The shared package `convolution_2d_pkg` holds:
  - the state encodings `ST_IDLE`, `ST_START`, `ST_RUN`, `ST_DONE` (2-bit);
  - the default `CNT_WIDTH`.
- The block has one FSM plus the counter in a single module; no sub-module.
- The synchronizers for `go` and `done_out` are instantiated by the parent, not inside this block.

## Test plan
- Nominal run: `go_sync` 0→1, `core_ready`=1, `core_done` pulse 10 cycles after `start`, then `go_sync`→0.
  - Required: one `start` pulse; `cycles`=11; `done_out` high until the cycle after `go_sync` falls; `timeout`=0 and `proto_err`=0.
- Core not ready: `go_sync`=1 with `core_ready`=0 for 5 cycles, then 1.
  - Required: `start` one cycle after `core_ready` is sampled high; no `start` before that.
- Watchdog: `TIMEOUT`=8, `core_done` never asserted.
  - Required: `done_out` rises 9 cycles after `start`; `timeout`=1; `cycles`=8.
  - Same setup with `core_done` asserted in the cycle `cycles`=8: `timeout`=0.
- Protocol error: `go_sync` drops 3 cycles into RUN; `core_done` arrives later.
  - Required: `proto_err`=1; `done_out` high for exactly 1 cycle; back to IDLE.
  - A new `go_sync` rise then clears `proto_err` in START.
- Saturation: `CNT_WIDTH`=4, core runs 20 cycles.
  - Required: `cycles`=15 held.
- Reset mid-RUN: assert `reset_n`=0 at run cycle 4.
  - Required: all outputs 0 immediately.
  - With `go_sync` held at 1 and `core_ready`=1 after reset release, a new `start` is issued one cycle after `go_sync` is first sampled high.
